// File: rtl/tone_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tone_gen_pkg
// Purpose  : Shared register map, bus encodings and helpers for ahb_tone_gen.
// Revision : 1.0 - initial release
// ============================================================================
package tone_gen_pkg;

    // Per-channel register index (word offset within a 16-byte channel slot)
    typedef enum logic [1:0] {
        REG_CTRL     = 2'd0,
        REG_PERIOD   = 2'd1,
        REG_DUTY     = 2'd2,
        REG_DURATION = 2'd3
    } ch_reg_e;

    localparam logic [5:0] WORD_STATUS = 6'h20;
    localparam logic [5:0] WORD_IRQEN  = 6'h21;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_BUSY    = 2;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [5:0] word;
        logic [3:0] strb;
    } dphase_t;

    function automatic logic [3:0] byte_strobes(input logic [1:0] size,
                                                input logic [1:0] addr);
        logic [3:0] s;
        case (size)
            HSIZE_BYTE[1:0]: s = 4'b0001 << addr;
            HSIZE_HALF[1:0]: s = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD[1:0]: s = 4'b1111;
            default:         s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_channel.sv
`default_nettype none
// ============================================================================
// Module   : tone_channel
// Purpose  : One PWM tone channel with period/duty and one-shot note length.
// Revision : 1.0 - initial release
// ============================================================================
module tone_channel
    import tone_gen_pkg::*;
#(
    parameter int CNT_W = 24,
    parameter int DUR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_ctrl,
    input  logic        wr_period,
    input  logic        wr_duty,
    input  logic        wr_duration,
    input  logic [31:0] wdata,
    input  logic [31:0] wmask,
    input  logic [1:0]  rd_sel,
    output logic        tone,
    output logic        done_pulse,
    output logic [31:0] rd_data
);

    logic             en;
    logic             oneshot;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] phase;
    logic [DUR_W-1:0] remaining;

    logic             running;
    logic             wrap;
    logic             expired;
    logic [1:0]       ctrl_new;
    logic [CNT_W-1:0] cnt_wdata;
    logic [CNT_W-1:0] cnt_wmask;
    logic [DUR_W-1:0] dur_wdata;
    logic [DUR_W-1:0] dur_wmask;
    logic             unused_bits;

    assign cnt_wdata   = wdata[CNT_W-1:0];
    assign cnt_wmask   = wmask[CNT_W-1:0];
    assign dur_wdata   = wdata[DUR_W-1:0];
    assign dur_wmask   = wmask[DUR_W-1:0];
    assign unused_bits = &{1'b0, wdata, wmask};

    assign running  = en && (period != '0);
    assign wrap     = running && (phase == period - CNT_W'(1));
    // A one-shot with nothing left to play must stay silent until it is retired
    assign expired  = en && oneshot && (remaining == '0);
    assign tone     = running && !expired && (phase < duty);
    assign done_pulse = expired || (en && oneshot && wrap && (remaining == DUR_W'(1)));
    assign ctrl_new = ({oneshot, en} & ~wmask[1:0]) | (wdata[1:0] & wmask[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en        <= 1'b0;
            oneshot   <= 1'b0;
            period    <= '0;
            duty      <= '0;
            phase     <= '0;
            remaining <= '0;
        end else begin
            if (wr_ctrl) begin
                en      <= ctrl_new[0];
                oneshot <= ctrl_new[1];
            end else if (done_pulse) begin
                en <= 1'b0;
            end

            if (wr_period)
                period <= (period & ~cnt_wmask) | (cnt_wdata & cnt_wmask);
            if (wr_duty)
                duty <= (duty & ~cnt_wmask) | (cnt_wdata & cnt_wmask);

            if (wr_period || !running || wrap || done_pulse || (wr_ctrl && !ctrl_new[0]))
                phase <= '0;
            else
                phase <= phase + CNT_W'(1);

            if (wr_duration)
                remaining <= (remaining & ~dur_wmask) | (dur_wdata & dur_wmask);
            else if (wrap && oneshot && (remaining != '0))
                remaining <= remaining - DUR_W'(1);
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            REG_CTRL: begin
                rd_data[CTRL_EN]      = en;
                rd_data[CTRL_ONESHOT] = oneshot;
                rd_data[CTRL_BUSY]    = tone;
            end
            REG_PERIOD:   rd_data = 32'(period);
            REG_DUTY:     rd_data = 32'(duty);
            REG_DURATION: rd_data = 32'(remaining);
            default:      rd_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ahb_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : ahb_tone_gen
// Purpose  : AHB-Lite multi-channel tone/PWM generator with done interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_tone_gen
    import tone_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24,
    parameter int DUR_W  = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [3:0]        HPROT,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    output logic              HRESP,
    output logic              BUZ,
    output logic [NUM_CH-1:0] BUZ_CH,
    output logic              IRQ
);

    dphase_t           dp;
    logic              accept;
    logic              wr_en;
    logic [31:0]       wmask;
    logic [NUM_CH-1:0] tones;
    logic [NUM_CH-1:0] done_set;
    logic [NUM_CH-1:0] done_clr;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] irqen;
    logic [31:0]       ch_rd [NUM_CH];
    logic              unused_bus;

    assign unused_bus = &{1'b0, HPROT, HADDR[31:8], HSIZE[2], HTRANS[0]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign accept    = HREADY && HSEL && HTRANS[1];
    assign wr_en     = dp.valid && dp.write;
    assign wmask     = lane_mask(dp.strb);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp <= '0;
        end else if (HREADY) begin
            dp.valid <= accept;
            dp.write <= HWRITE;
            dp.word  <= HADDR[7:2];
            dp.strb  <= byte_strobes(HSIZE[1:0], HADDR[1:0]);
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic hit;
            assign hit = wr_en && !dp.word[5] && (dp.word[4:2] == 3'(c));

            tone_channel #(
                .CNT_W (CNT_W),
                .DUR_W (DUR_W)
            ) u_ch (
                .clk         (HCLK),
                .rst_n       (HRESETn),
                .wr_ctrl     (hit && (dp.word[1:0] == REG_CTRL)),
                .wr_period   (hit && (dp.word[1:0] == REG_PERIOD)),
                .wr_duty     (hit && (dp.word[1:0] == REG_DUTY)),
                .wr_duration (hit && (dp.word[1:0] == REG_DURATION)),
                .wdata       (HWDATA),
                .wmask       (wmask),
                .rd_sel      (dp.word[1:0]),
                .tone        (tones[c]),
                .done_pulse  (done_set[c]),
                .rd_data     (ch_rd[c])
            );
        end
    endgenerate

    assign done_clr = (wr_en && (dp.word == WORD_STATUS)) ?
                      (HWDATA[NUM_CH-1:0] & wmask[NUM_CH-1:0]) : '0;

    // Hardware set is ORed in after the clear so a coincident W1C cannot lose it
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            done   <= '0;
            irqen  <= '0;
            BUZ_CH <= '0;
            BUZ    <= 1'b0;
        end else begin
            done <= (done & ~done_clr) | done_set;
            if (wr_en && (dp.word == WORD_IRQEN))
                irqen <= (irqen & ~wmask[NUM_CH-1:0]) | (HWDATA[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
            BUZ_CH <= tones;
            BUZ    <= |tones;
        end
    end

    assign IRQ = |(done & irqen);

    always_comb begin
        HRDATA = '0;
        if (dp.valid && !dp.write) begin
            if (!dp.word[5]) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (dp.word[4:2] == 3'(i))
                        HRDATA = ch_rd[i];
                end
            end else if (dp.word == WORD_STATUS) begin
                HRDATA = 32'(done);
            end else if (dp.word == WORD_IRQEN) begin
                HRDATA = 32'(irqen);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_tone_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_tone_gen
// Purpose  : Self-checking bench for ahb_tone_gen with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_tone_gen;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL    = 1'b0;
    logic [31:0] HADDR   = '0;
    logic [1:0]  HTRANS  = '0;
    logic [2:0]  HSIZE   = 3'd2;
    logic [3:0]  HPROT   = '0;
    logic        HWRITE  = 1'b0;
    logic [31:0] HWDATA  = '0;
    logic        HREADY  = 1'b1;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        BUZ;
    logic [3:0]  BUZ_CH;
    logic        IRQ;

    ahb_tone_gen #(.NUM_CH(4), .CNT_W(24), .DUR_W(16)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .BUZ       (BUZ),
        .BUZ_CH    (BUZ_CH),
        .IRQ       (IRQ)
    );

    always #5 HCLK = ~HCLK;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_pend = 1'b0;
    bit          bus_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Independent model of the one-cycle data phase: a read accepted on this
    // edge must present its data during the following cycle.
    always @(posedge HCLK)
        rd_pend <= HRESETn && HSEL && HTRANS[1] && HREADY && !HWRITE;

    always @(negedge HCLK) begin
        string t;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0)
            bus_err = 1'b1;
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                t = tag_q.pop_front();
                check(t, HRDATA, exp_q.pop_front());
            end
        end
    end

    task automatic ahb_write_sz(input logic [7:0] a, input logic [31:0] d, input logic [2:0] sz);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = {24'h0, a}; HWRITE = 1'b1; HSIZE = sz;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        ahb_write_sz(a, d, 3'd2);
    endtask

    // Two back-to-back word writes; the second commits one edge after the first
    task automatic wr2(input logic [7:0] a1, input logic [31:0] d1,
                       input logic [7:0] a2, input logic [31:0] d2);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = {24'h0, a1}; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HWDATA = d1; HADDR = {24'h0, a2};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d2;
        @(posedge HCLK); #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = {24'h0, a}; HWRITE = 1'b0; HSIZE = 3'd2;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    function automatic logic [7:0] ra(input int c, input int r);
        return 8'(16 * c + 4 * r);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic b0, b2, e;

        // Reset and idle readback
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_buz", 32'(BUZ), 32'd0);
        check("rst_buzch", 32'(BUZ_CH), 32'd0);
        check("rst_irq", 32'(IRQ), 32'd0);
        HRESETn = 1'b1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                rd(ra(c, r), 32'd0, $sformatf("rst_c%0d_r%0d", c, r));
        rd(8'h80, 32'd0, "rst_status");
        rd(8'h84, 32'd0, "rst_irqen");

        // Continuous square wave on ch0
        wr(ra(0, 1), 32'd10);
        wr(ra(0, 2), 32'd5);
        wr(ra(0, 0), 32'd1);
        check("sq_first", 32'(BUZ_CH[0]), 32'd0);
        for (int k = 0; k < 20; k++) begin
            @(posedge HCLK); #1;
            e = (k % 10) < 5;
            check("sq_ch0", 32'(BUZ_CH[0]), 32'(e));
            check("sq_buz", 32'(BUZ), 32'(e));
        end

        // Duty edge cases
        wr(ra(0, 2), 32'd0);
        @(posedge HCLK); #1;
        for (int k = 0; k < 10; k++) begin
            @(posedge HCLK); #1;
            check("duty0", 32'(BUZ_CH[0]), 32'd0);
        end
        wr(ra(0, 2), 32'd12);
        @(posedge HCLK); #1;
        for (int k = 0; k < 12; k++) begin
            @(posedge HCLK); #1;
            check("duty_big", 32'(BUZ_CH[0]), 32'd1);
        end
        wr(ra(0, 1), 32'd0);
        @(posedge HCLK); #1;
        for (int k = 0; k < 10; k++) begin
            @(posedge HCLK); #1;
            check("period0", 32'(BUZ_CH[0]), 32'd0);
        end
        rd(ra(0, 0), 32'd1, "period0_ctrl");
        wr(ra(0, 0), 32'd0);
        rd(ra(0, 0), 32'd0, "ch0_off");

        // One-shot with interrupt on ch1
        wr(ra(1, 1), 32'd4);
        wr(ra(1, 2), 32'd2);
        wr(ra(1, 3), 32'd3);
        wr(8'h84, 32'h2);
        wr(ra(1, 0), 32'd3);
        for (int k = 0; k < 14; k++) begin
            @(posedge HCLK); #1;
            e = (k < 12) && ((k % 4) < 2);
            check("os_tone", 32'(BUZ_CH[1]), 32'(e));
            check("os_irq", 32'(IRQ), 32'(k >= 11));
        end
        rd(ra(1, 0), 32'd2, "os_ctrl");
        rd(8'h80, 32'h2, "os_status");
        rd(ra(1, 3), 32'd0, "os_dur");
        wr(8'h80, 32'h2);
        check("w1c_irq", 32'(IRQ), 32'd0);
        rd(8'h80, 32'h0, "w1c_status");

        // Zero remaining count at enable: retire next cycle, no pulse
        wr(ra(1, 0), 32'd3);
        check("zd_irq_pre", 32'(IRQ), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge HCLK); #1;
            check("zd_tone", 32'(BUZ_CH[1]), 32'd0);
            check("zd_irq", 32'(IRQ), 32'd1);
        end
        rd(ra(1, 0), 32'd2, "zd_ctrl");
        wr(8'h80, 32'h2);

        // Byte/half-word lanes and unmapped space
        ahb_write_sz(8'h25, 32'h0000_AB00, 3'd0);
        rd(ra(2, 1), 32'h00AB00, "byte_period");
        ahb_write_sz(8'h2A, 32'h1234_5678, 3'd1);
        rd(ra(2, 2), 32'h340000, "half_duty");
        rd(8'h90, 32'd0, "unmapped_rd");
        rd(8'h40, 32'd0, "absent_ch_rd");
        wr(8'h90, 32'hFFFF_FFFF);
        rd(8'h84, 32'h2, "unmapped_wr");

        // W1C landing on the same edge as a hardware DONE set
        wr2(ra(1, 0), 32'd3, 8'h80, 32'h2);
        rd(8'h80, 32'h2, "w1c_collide");
        check("w1c_collide_irq", 32'(IRQ), 32'd1);
        wr(8'h80, 32'h2);
        rd(8'h80, 32'h0, "w1c_after");

        // Two channels ORed onto BUZ
        wr(ra(0, 1), 32'd6);
        wr(ra(0, 2), 32'd3);
        wr(ra(2, 1), 32'd9);
        wr(ra(2, 2), 32'd3);
        wr2(ra(0, 0), 32'd1, ra(2, 0), 32'd1);
        for (int j = 1; j <= 36; j++) begin
            @(posedge HCLK); #1;
            b0 = (j % 6) < 3;
            b2 = ((j - 1) % 9) < 3;
            check("mc_ch", 32'(BUZ_CH), {28'd0, 1'b0, b2, 1'b0, b0});
            check("mc_buz", 32'(BUZ), 32'(b0 | b2));
        end

        // Reset in the middle of a tone
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        check("midrst_buz", 32'(BUZ), 32'd0);
        check("midrst_buzch", 32'(BUZ_CH), 32'd0);
        check("midrst_irq", 32'(IRQ), 32'd0);
        HRESETn = 1'b1;
        rd(8'h80, 32'd0, "midrst_status");
        rd(ra(0, 0), 32'd0, "midrst_ctrl");

        @(posedge HCLK); #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("bus_const", 32'(bus_err), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
